// File: rtl/sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbox_pkg
// Description : S-DES S0/S1 default tables and slice-to-address mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package sbox_pkg;

    typedef enum logic [1:0] {
        DEF_ZERO = 2'd0,
        DEF_S0   = 2'd1,
        DEF_S1   = 2'd2
    } sbox_def_e;

    // Indexed by {row[1:0], col[1:0]}
    localparam logic [1:0] SDES_S0 [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };

    localparam logic [1:0] SDES_S1 [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    // Slice of width w -> {s[w-1], s[0], s[w-2:1]}
    function automatic int unsigned sbox_addr(input int unsigned s, input int unsigned w);
        int unsigned row;
        int unsigned col;
        row = (((s >> (w - 32'd1)) & 32'd1) << 1) | (s & 32'd1);
        col = (s >> 1) & ((32'd1 << (w - 32'd2)) - 32'd1);
        return (row << (w - 32'd2)) | col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_table.sv
`default_nettype none
// ============================================================================
// Module      : sbox_table
// Description : One writable 2^IN_W x OUT_W lookup table with default reload.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_table
    import sbox_pkg::*;
#(
    parameter int        IN_W     = 4,
    parameter int        OUT_W    = 2,
    parameter sbox_def_e DEF_KIND = DEF_ZERO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic             i_restore,
    input  logic [IN_W-1:0]  i_waddr,
    input  logic [OUT_W-1:0] i_wdata,
    input  logic [IN_W-1:0]  i_raddr,
    output logic [OUT_W-1:0] o_rdata
);

    localparam int DEPTH    = 2 ** IN_W;
    localparam bit USE_SDES = (IN_W == 4) && (OUT_W == 2);

    function automatic logic [OUT_W-1:0] def_entry(input int idx);
        logic [3:0] k;
        k = idx[3:0];
        if (!USE_SDES || DEF_KIND == DEF_ZERO) return '0;
        else if (DEF_KIND == DEF_S0)           return OUT_W'(SDES_S0[k]);
        return OUT_W'(SDES_S1[k]);
    endfunction

    logic [OUT_W-1:0] r_mem [DEPTH];

    // Restore has priority over a coincident write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= def_entry(k);
        end else if (i_restore) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= def_entry(k);
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read; a write on the same edge is not seen by the capturing stage
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sbox_bank_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sbox_bank_pipe
// Description : Two-stage valid/ready pipelined bank of programmable S-boxes.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_bank_pipe
    import sbox_pkg::*;
#(
    parameter  int N_SBOX = 2,
    parameter  int IN_W   = 4,
    parameter  int OUT_W  = 2,
    localparam int SEL_W  = (N_SBOX > 1) ? $clog2(N_SBOX) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [N_SBOX*IN_W-1:0]  i_in_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [N_SBOX*OUT_W-1:0] o_out_data,
    input  logic                    i_cfg_we,
    input  logic [SEL_W-1:0]        i_cfg_sel,
    input  logic [IN_W-1:0]         i_cfg_addr,
    input  logic [OUT_W-1:0]        i_cfg_data,
    input  logic                    i_cfg_restore
);

    logic                    r_s1_valid;
    logic [N_SBOX*IN_W-1:0]  r_s1_data;
    logic                    r_s2_valid;
    logic [N_SBOX*OUT_W-1:0] r_s2_data;
    logic [N_SBOX*OUT_W-1:0] w_lookup;
    logic                    w_adv1;
    logic                    w_adv2;

    assign w_adv2     = !r_s2_valid || i_out_ready;
    assign w_adv1     = !r_s1_valid || w_adv2;
    assign o_in_ready = w_adv1;

    generate
        for (genvar gi = 0; gi < N_SBOX; gi++) begin : g_sbox
            logic [IN_W-1:0] w_slice;
            logic [IN_W-1:0] w_raddr;
            logic            w_we;

            assign w_slice = r_s1_data[(N_SBOX-gi)*IN_W-1 -: IN_W];
            assign w_raddr = IN_W'(sbox_addr(32'(w_slice), 32'(IN_W)));
            // Out-of-range selects match no table and are dropped here
            assign w_we    = i_cfg_we && (i_cfg_sel == SEL_W'(gi));

            sbox_table #(
                .IN_W     (IN_W),
                .OUT_W    (OUT_W),
                .DEF_KIND ((gi % 2 == 0) ? DEF_S0 : DEF_S1)
            ) u_table (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_we      (w_we),
                .i_restore (i_cfg_restore),
                .i_waddr   (i_cfg_addr),
                .i_wdata   (i_cfg_data),
                .i_raddr   (w_raddr),
                .o_rdata   (w_lookup[(N_SBOX-gi)*OUT_W-1 -: OUT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= i_in_valid;
                if (i_in_valid) r_s1_data <= i_in_data;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) r_s2_data <= w_lookup;
            end
        end
    end

    assign o_out_valid = r_s2_valid;
    assign o_out_data  = r_s2_data;

endmodule
`default_nettype wire
